de0_nano_soc_baseline: RTL and testbench

- Top-level combination lock for the DE0-Nano-SoC baseline project.
- The user sets a 4-bit digit on SW[3:0] and presses KEY[1] to enter it.
- Entering the 7-digit code 0,9,1,3,0,1,1 in order opens the lock.
- LEDs show entry progress and the unlocked state. KEY[0] returns the lock to its idle state.

---
 rtl/lock_pkg.sv | 35 +++
 rtl/edge_sync.sv | 41 ++++
 rtl/de0_nano_soc_baseline.sv | 89 ++++++++
 tb/tb_de0_nano_soc_baseline.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock.
//   STATE_W      : width of the matched-digit counter (0..CODE_LEN)
//   DEF_CODE_LEN : default number of code digits
//   DEF_CODE     : default packed code, first digit in the top nibble
//   UNLOCKED     : state encoding of the open lock for the default code
//   code_digit() : extracts digit k of a packed code
package lock_pkg;

    localparam int          STATE_W      = 3;
    localparam int          DEF_CODE_LEN = 7;
    localparam logic [27:0] DEF_CODE     = 28'h0913011;

    // The open state is simply "all digits matched".
    function automatic logic [STATE_W-1:0] unlocked_state(input int code_len);
        return STATE_W'(code_len);
    endfunction

    localparam logic [STATE_W-1:0] UNLOCKED = unlocked_state(DEF_CODE_LEN);

    // Digit k lives at CODE[4*(code_len-1-k) +: 4]. Indices past the end
    // return 0 so the caller can evaluate this for every state value.
    function automatic logic [3:0] code_digit(input logic [27:0] code,
                                              input int          code_len,
                                              input int          k);
        logic [3:0] digit;
        digit = 4'd0;
        for (int i = 0; i < 7; i++) begin
            if (i == k && k < code_len) begin
                digit = code[4*(code_len-1-i) +: 4];
            end
        end
        return digit;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk   : sampling clock
//   rst   : asynchronous active-high reset, clears all three flops
//   d     : asynchronous level input
//   pulse : one-cycle pulse per 0->1 transition of the synchronized level
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic ksync1_q = 1'b0;
    logic ksync2_q = 1'b0;
    logic kprev_q  = 1'b0;
    logic ksync1_d;
    logic ksync2_d;
    logic kprev_d;

    always_comb begin
        ksync1_d = d;
        ksync2_d = ksync1_q;
        kprev_d  = ksync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ksync1_q <= 1'b0;
            ksync2_q <= 1'b0;
            kprev_q  <= 1'b0;
        end else begin
            ksync1_q <= ksync1_d;
            ksync2_q <= ksync2_d;
            kprev_q  <= kprev_d;
        end
    end

    // High for exactly one cycle however long the input stays high.
    assign pulse = ksync2_q & ~kprev_q;

endmodule

// File: rtl/de0_nano_soc_baseline.sv
// Combination lock top level for the DE0-Nano-SoC baseline project.
//   CLOCK_50 : system clock, single domain
//   KEY[0]   : asynchronous active-high reset
//   KEY[1]   : enter button, a 0->1 transition enters the digit on SW
//   SW[3:0]  : digit to enter
//   LED[6:0] : thermometer of matched digits
//   LED[7]   : unlocked indicator
// A press first sampled at edge n moves the state at n+2 and the
// registered LEDs at n+3. Once unlocked, only reset closes the lock.
module de0_nano_soc_baseline
    import lock_pkg::*;
#(
    parameter int          CODE_LEN = DEF_CODE_LEN,
    parameter logic [27:0] CODE     = DEF_CODE
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [7:0] LED
);

    localparam logic [STATE_W-1:0] OPEN_ST = unlocked_state(CODE_LEN);

    logic rst;
    logic enter;

    logic [3:0]         swsync1_q = 4'd0;
    logic [3:0]         swsync2_q = 4'd0;
    logic [STATE_W-1:0] state_q   = '0;
    logic [7:0]         led_q     = 8'h00;
    logic [3:0]         swsync1_d;
    logic [3:0]         swsync2_d;
    logic [STATE_W-1:0] state_d;
    logic [7:0]         led_d;
    logic [3:0]         cur_digit;
    logic [3:0]         first_digit;

    assign rst = KEY[0];

    edge_sync u_key_sync (
        .clk   (CLOCK_50),
        .rst   (rst),
        .d     (KEY[1]),
        .pulse (enter)
    );

    always_comb begin
        swsync1_d   = SW;
        swsync2_d   = swsync1_q;
        cur_digit   = code_digit(CODE, CODE_LEN, int'(state_q));
        first_digit = code_digit(CODE, CODE_LEN, 0);

        // The state counts matched digits. A wrong digit that equals the
        // first code digit restarts the match at one instead of zero.
        state_d = state_q;
        if (enter && state_q != OPEN_ST) begin
            if (swsync2_q == cur_digit) begin
                state_d = state_q + 1'b1;
            end else if (swsync2_q == first_digit) begin
                state_d = STATE_W'(1);
            end else begin
                state_d = '0;
            end
        end

        led_d = 8'h00;
        for (int j = 0; j < 7; j++) begin
            led_d[j] = (j < CODE_LEN) && (int'(state_q) > j);
        end
        led_d[7] = (state_q == OPEN_ST);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            swsync1_q <= 4'd0;
            swsync2_q <= 4'd0;
            state_q   <= '0;
            led_q     <= 8'h00;
        end else begin
            swsync1_q <= swsync1_d;
            swsync2_q <= swsync2_d;
            state_q   <= state_d;
            led_q     <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_de0_nano_soc_baseline.sv
module tb_de0_nano_soc_baseline;

    logic       clk = 1'b0;
    logic [1:0] key = 2'b00;
    logic [3:0] sw  = 4'd0;
    logic [7:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_led = 8'h00;

    de0_nano_soc_baseline dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LED      (led)
    );

    always #10 clk = ~clk;

    // Present a digit for 10 cycles, then hold KEY[1] for 'hold' cycles.
    // The expected LED value goes onto the scoreboard at the press and is
    // popped three edges after the first edge that samples it.
    task automatic press(input logic [3:0] digit, input int hold, input logic [7:0] exp_led);
        logic [7:0] exp;
        @(negedge clk);
        sw = digit;
        repeat (10) @(negedge clk);
        exp_q.push_back(exp_led);
        key[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (led !== last_led) begin
            n_fail++;
            $display("FAIL press_early sw=%0d: LED=%h expected %h", digit, led, last_led);
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL press_latency sw=%0d: LED=%h expected %h", digit, led, exp);
        end
        last_led = exp;
        if (hold > 4) repeat (hold - 4) @(posedge clk);
        @(negedge clk);
        key[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
        key[0] = 1'b0;
        last_led = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        // Power-up, no reset pulse ever applied.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (led !== 8'h00) begin
                n_fail++;
                $display("FAIL power_up cycle %0d: LED=%h expected 00", i, led);
            end
        end
    endtask

    task automatic test_wrong_digit();
        reset_pulse();
        press(4'd6, 5, 8'h00);
        press(4'd0, 5, 8'h01);
    endtask

    task automatic test_full_code();
        logic [3:0] digits [7] = '{4'd0, 4'd9, 4'd1, 4'd3, 4'd0, 4'd1, 4'd1};
        logic [7:0] leds   [7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'hFF};
        reset_pulse();
        for (int i = 0; i < 7; i++) press(digits[i], 5, leds[i]);
        press(4'd1, 5, 8'hFF);
        press(4'd0, 5, 8'hFF);
    endtask

    task automatic test_mid_error();
        reset_pulse();
        press(4'd0, 5, 8'h01);
        press(4'd9, 5, 8'h03);
        press(4'd1, 5, 8'h07);
        press(4'd5, 5, 8'h00);
        press(4'd0, 5, 8'h01);
        press(4'd9, 5, 8'h03);
        press(4'd0, 5, 8'h01);
    endtask

    task automatic test_async_reset();
        logic [3:0] digits [7] = '{4'd0, 4'd9, 4'd1, 4'd3, 4'd0, 4'd1, 4'd1};
        logic [7:0] leds   [7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'hFF};
        reset_pulse();
        for (int i = 0; i < 7; i++) press(digits[i], 5, leds[i]);
        @(negedge clk);
        key[0] = 1'b1;
        #1;
        n_checks++;
        if (led !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: LED=%h expected 00", led);
        end
        repeat (5) @(negedge clk);
        key[0] = 1'b0;
        last_led = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (led !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset: LED=%h expected 00", led);
        end
        press(4'd0, 5, 8'h01);
    endtask

    task automatic test_hold();
        reset_pulse();
        press(4'd0, 50, 8'h01);
        repeat (10) @(negedge clk);
        n_checks++;
        if (led !== 8'h01) begin
            n_fail++;
            $display("FAIL hold_release: LED=%h expected 01", led);
        end
        press(4'd0, 5, 8'h01);
    endtask

    initial begin
        test_reset();
        test_wrong_digit();
        test_full_code();
        test_mid_error();
        test_async_reset();
        test_hold();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
